uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side byte buffer behind a Uart8 receiver. Captures one byte per completed frame from the rxDone/rxErr/rxOut interface and queues it in a first-word-fall-through FIFO.
- Presents the queued bytes to the consumer on a valid/ready handshake.
- Drops errored frames and counts them. Flags overflow when bytes arrive faster than the consumer drains them, e.g. during TURBO_FRAMES back-to-back streams.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 = 16 entries, legal range 1..8.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, same clock as the Uart8 instance.
- reset  input  1  synchronous, active-high reset.
- rxDone  input  1  Uart8 frame-complete strobe, treated as a level and edge-detected.
- rxErr  input  1  Uart8 frame error, sampled together with rxDone.
- rxOut  input  8  Uart8 received byte, sampled together with rxDone.
- outValid  output  1  head entry available.
- outReady  input  1  consumer accepts head entry this cycle.
- outByte  output  8  head entry data; only meaningful while outValid=1.
- count  output  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2.
- overflow  output  1  sticky: at least one good byte dropped because the FIFO was full.
- errCount  output  ERR_W  saturating count of frames dropped due to rxErr.
- clearFlags  input  1  clears overflow and errCount.

Behaviour:
- Reset (synchronous, on the clk edge while reset=1):
  - read pointer, write pointer and count = 0.
  - outValid=0, overflow=0, errCount=0.
  - outByte is don't-care, but the bench expects a register reset value of 8'h00.
  - rxDone delay register (doneQ) resets to 1. A rxDone level held high through reset therefore produces no capture; the next capture needs a fresh rising edge.
  - Reset mid-stream discards all queued data; no partial state survives.
- Capture event: rxDone=1 and doneQ=0 (rising edge). doneQ <= rxDone every cycle. At most one capture per rising edge, however long rxDone stays high.
- On a capture event:
  - rxErr=1: byte is dropped and errCount increments, saturating at 2**ERR_W-1. The FIFO is untouched.
  - rxErr=0 and push is allowed: rxOut is written at the write pointer, which then advances, wrapping modulo depth.
  - rxErr=0 and push is not allowed: byte is dropped and overflow is set.
- Push allowed: count < depth, or count == depth with a pop in the same cycle. A simultaneous push and pop on a full FIFO succeeds; count stays at depth.
- Pop: outValid=1 and outReady=1. The read pointer advances, wrapping modulo depth. outReady while outValid=0 is ignored.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Push and pop on an empty FIFO cannot coincide, because outValid=0 in that case.
- outValid = (count != 0), registered.
- outByte = mem[read pointer], combinational read of the registered memory.
- Latency: a byte captured at clk edge N gives outValid=1 and correct outByte after edge N, i.e. visible in cycle N+1.
- Order: strict FIFO across wrap-around.
- clearFlags=1: overflow <= 0 and errCount <= 0 on that edge.
  - If an overflow or error event occurs on the same edge, the event wins: overflow=1, or errCount=1.
  - clearFlags never affects FIFO contents or count.
- No combinational path from outReady to outValid.
- count and flags change only on clk edges.

Test Plan:
- Stream 30,24,19,25,91 with one rxDone pulse (rxErr=0) per byte; outReady=1 throughout. Expect outValid high one cycle after each capture, outByte sequence 30,24,19,25,91, count never above 1, overflow=0.
- Hold outReady=0 and capture 17 good bytes 0..16. Expect count=16 after byte 15, overflow=1 after byte 16 with count still 16. Then drain with outReady=1; expect bytes 0..15 in order and count=0.
- Pre-fill 16 bytes. Issue a capture of 8'hAA on the same cycle as a pop. Expect overflow=0, count=16, and AA as the last entry drained after 15 older bytes.
- rxDone held high 10 cycles for a byte of 8'h55. Expect exactly one entry. Separately, pulse rxDone with rxErr=1 and byte 8'hFF, 300 times. Expect errCount saturated at 255, FIFO empty, outValid=0.
- Pulse clearFlags on the same edge as an errored capture. Expect errCount=1. Clear again with no event; expect errCount=0 and overflow=0.
- Queue 5 bytes, then assert reset for 1 cycle while rxDone is held high. Expect count=0, outValid=0, flags=0, and no capture until rxDone drops and rises again.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module  : uart_rx_fifo
// Brief   : Receive-side byte FIFO behind a Uart8 receiver, valid/ready output
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int ERR_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rxDone,
  input  logic                  rxErr,
  input  logic [7:0]            rxOut,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [7:0]            outByte,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [ERR_W-1:0]      errCount,
  input  logic                  clearFlags
);

  localparam int                  C_DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem_q [C_DEPTH];
  logic [7:0]            mem_d [C_DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  valid_q, valid_d;
  logic                  overflow_q, overflow_d;
  logic [ERR_W-1:0]      err_q, err_d;
  logic                  done_q, done_d;

  logic w_capture;
  logic w_pop;
  logic w_push;
  logic w_ovf_evt;
  logic w_err_evt;

  always_comb begin
    w_capture = rxDone & ~done_q;
    w_pop     = valid_q & outReady;
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    w_push    = w_capture & ~rxErr & ((count_q != C_FULL) | w_pop);
    w_ovf_evt = w_capture & ~rxErr & (count_q == C_FULL) & ~w_pop;
    w_err_evt = w_capture & rxErr;

    done_d   = rxDone;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (w_push) begin
      mem_d[wr_ptr_q] = rxOut;
      wr_ptr_d        = wr_ptr_q + DEPTH_LOG2'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    end
    if (w_push && !w_pop) begin
      count_d = count_q + (DEPTH_LOG2 + 1)'(1);
    end else if (w_pop && !w_push) begin
      count_d = count_q - (DEPTH_LOG2 + 1)'(1);
    end
    valid_d = (count_d != '0);

    // Events on the clearing edge take priority over the clear.
    overflow_d = clearFlags ? 1'b0 : overflow_q;
    if (w_ovf_evt) begin
      overflow_d = 1'b1;
    end
    err_d = clearFlags ? '0 : err_q;
    if (w_err_evt) begin
      if (clearFlags) begin
        err_d = ERR_W'(1);
      end else if (!(&err_q)) begin
        err_d = err_q + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < C_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= '0;
      done_q     <= 1'b1;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign outValid = valid_q;
  assign outByte  = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;
  assign errCount = err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module  : tb_uart_rx_fifo
// Brief   : Directed bench for uart_rx_fifo with a queue-based reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] rxOut;
  logic       outValid;
  logic       outReady;
  logic [7:0] outByte;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] errCount;
  logic       clearFlags;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH_LOG2(4), .ERR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .rxDone     (rxDone),
    .rxErr      (rxErr),
    .rxOut      (rxOut),
    .outValid   (outValid),
    .outReady   (outReady),
    .outByte    (outByte),
    .count      (count),
    .overflow   (overflow),
    .errCount   (errCount),
    .clearFlags (clearFlags)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a byte queue plus flag counters, stepped on every edge.
  logic [7:0] m_q[$];
  int         m_err     = 0;
  bit         m_ovf     = 0;
  bit         m_prev    = 1;
  bit         m_started = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_err     = 0;
      m_ovf     = 0;
      m_prev    = 1;
      m_started = 1;
    end else if (m_started) begin
      bit cap;
      cap = rxDone && !m_prev;
      m_prev = rxDone;
      if (outReady && m_q.size() != 0) void'(m_q.pop_front());
      if (clearFlags) begin
        m_err = 0;
        m_ovf = 0;
      end
      if (cap) begin
        if (rxErr) m_err = (m_err < 255) ? m_err + 1 : 255;
        else if (m_q.size() < 16) m_q.push_back(rxOut);
        else m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("mdl_valid", outValid, (m_q.size() != 0));
      chk("mdl_count", count, m_q.size());
      if (m_q.size() != 0) chk("mdl_byte", outByte, m_q[0]);
      chk("mdl_overflow", overflow, m_ovf);
      chk("mdl_errcount", errCount, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic e);
    rxDone = 1'b1;
    rxErr  = e;
    rxOut  = b;
    tick();
    rxDone = 1'b0;
    rxErr  = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] t1 [5];
    t1[0] = 8'd30; t1[1] = 8'd24; t1[2] = 8'd19; t1[3] = 8'd25; t1[4] = 8'd91;

    reset = 1'b1; rxDone = 1'b0; rxErr = 1'b0; rxOut = 8'h00;
    outReady = 1'b0; clearFlags = 1'b0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", outValid, 0);
    chk("rst_count", count, 0);
    chk("rst_byte", outByte, 8'h00);
    chk("rst_flags", {overflow, errCount}, 0);
    tick();

    // Streaming with the consumer always ready.
    outReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rxDone = 1'b1; rxOut = t1[i];
      tick();
      rxDone = 1'b0;
      @(negedge clk);
      chk("t1_valid", outValid, 1);
      chk("t1_byte", outByte, t1[i]);
      chk("t1_count", count, 1);
      tick();
    end
    chk("t1_overflow", overflow, 0);

    // Fill to full, then one more good byte overflows.
    outReady = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    @(negedge clk);
    chk("t2_full_count", count, 16);
    chk("t2_no_ovf", overflow, 0);
    send(8'd16, 1'b0);
    @(negedge clk);
    chk("t2_ovf", overflow, 1);
    chk("t2_count_held", count, 16);
    tick();
    outReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("t2_drain", outByte, i);
      tick();
    end
    @(negedge clk);
    chk("t2_empty", count, 0);
    tick();
    outReady = 1'b0;
    clearFlags = 1'b1;
    tick();
    clearFlags = 1'b0;

    // Push into a full FIFO on the same edge as a pop.
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 1'b0);
    rxDone = 1'b1; rxOut = 8'hAA; outReady = 1'b1;
    tick();
    rxDone = 1'b0; outReady = 1'b0;
    @(negedge clk);
    chk("t3_ovf", overflow, 0);
    chk("t3_count", count, 16);
    tick();
    outReady = 1'b1;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      chk("t3_drain", outByte, 8'h10 + i);
      tick();
    end
    @(negedge clk);
    chk("t3_last", outByte, 8'hAA);
    tick();
    outReady = 1'b0;

    // Long rxDone level yields a single capture.
    rxDone = 1'b1; rxOut = 8'h55;
    for (int i = 0; i < 10; i++) tick();
    rxDone = 1'b0;
    tick();
    @(negedge clk);
    chk("t4_single", count, 1);
    chk("t4_byte", outByte, 8'h55);
    outReady = 1'b1;
    tick();
    outReady = 1'b0;

    // Error counter saturation.
    for (int i = 0; i < 300; i++) send(8'hFF, 1'b1);
    @(negedge clk);
    chk("t4_err_sat", errCount, 255);
    chk("t4_err_empty", count, 0);
    chk("t4_err_valid", outValid, 0);
    tick();

    // Clear coinciding with an errored capture: the event wins.
    rxDone = 1'b1; rxErr = 1'b1; clearFlags = 1'b1;
    tick();
    rxDone = 1'b0; rxErr = 1'b0; clearFlags = 1'b0;
    @(negedge clk);
    chk("t5_evt_wins", errCount, 1);
    tick();
    clearFlags = 1'b1;
    tick();
    clearFlags = 1'b0;
    @(negedge clk);
    chk("t5_cleared", {overflow, errCount}, 0);
    tick();

    // Reset mid-stream with rxDone held high.
    send(8'h01, 1'b1);
    for (int i = 0; i < 5; i++) send(8'(8'h40 + i), 1'b0);
    @(negedge clk);
    chk("t6_pre_count", count, 5);
    tick();
    rxDone = 1'b1; rxOut = 8'h77; reset = 1'b1;
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    chk("t6_count", count, 0);
    chk("t6_valid", outValid, 0);
    chk("t6_flags", {overflow, errCount}, 0);
    tick();
    rxDone = 1'b0;
    tick();
    rxDone = 1'b1; rxOut = 8'h88;
    tick();
    rxDone = 1'b0;
    @(negedge clk);
    chk("t6_recapture", count, 1);
    chk("t6_byte", outByte, 8'h88);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
